// File: rtl/bp_tanh_grad.sv
// bp_tanh_grad -- backward pass of the LSTM tanh gate.
//   From the stored forward activation a and upstream error e it computes
//   delta = e*(1-a^2) and then streams g[k] = delta*x[k] for k = 0..NUM-1,
//   reading x from a buffer with one cycle of read latency.
//   All arithmetic is signed fixed point with FRAC fractional bits. Every
//   result is truncated and then saturated to the WIDTH range.
//
// Optional feature: define BP_TANH_ACC_EN to add a NUM-entry gradient bank.
//   When i_acc is captured high, each gradient is added to the bank and the
//   sum is written back. i_clr, sampled in IDLE, zeroes the bank.
//
// Ports:
//   clk, rst            clock (rising edge); synchronous active-high reset
//   i_start             start pulse, sampled only in IDLE
//   i_act, i_err        forward activation a and error e, captured with i_start
//   i_acc, i_clr        accumulate / clear-bank controls (bank build only)
//   i_x                 buffer data for the address issued the previous cycle
//   o_addr              buffer read address
//   o_delta             registered delta, held until the next pass
//   o_grad, o_grad_idx  gradient word and its index, qualified by o_grad_valid
//   o_busy, o_done      pass in progress / one-cycle end-of-pass pulse
module bp_tanh_grad #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 20,
  parameter int NUM   = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_act,
  input  logic [WIDTH-1:0] i_err,
  input  logic             i_acc,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_x,
  output logic [AW-1:0]    o_addr,
  output logic [WIDTH-1:0] o_delta,
  output logic [WIDTH-1:0] o_grad,
  output logic [AW-1:0]    o_grad_idx,
  output logic             o_grad_valid,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;
  localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
  // Saturation limits, sign-extended to the full product width.
  localparam logic signed [2*WIDTH-1:0] MAXP = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [2*WIDTH-1:0] MINP = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic [AW-1:0] LAST = AW'(NUM-1);

  typedef enum logic [2:0] {S_IDLE, S_SQR, S_DELTA, S_GRAD, S_DONE} state_t;

  // Fixed-point multiply: take the product bits [WIDTH+FRAC-1:FRAC], which
  // is a floor shift of the full product, then clamp to the WIDTH range.
  function automatic logic [WIDTH-1:0] sat_mul(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic signed [2*WIDTH-1:0] p;
    p = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    p = p >>> FRAC;
    if (p > MAXP)      sat_mul = MAXV;
    else if (p < MINP) sat_mul = MINV;
    else               sat_mul = p[WIDTH-1:0];
  endfunction

  // Saturating add/sub. Overflow occurs when the two top bits of the
  // WIDTH+1-bit result differ.
  function automatic logic [WIDTH-1:0] sat_as(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic             sub);
    logic [WIDTH:0] s;
    s = sub ? ({a[WIDTH-1], a} - {b[WIDTH-1], b})
            : ({a[WIDTH-1], a} + {b[WIDTH-1], b});
    if (s[WIDTH] != s[WIDTH-1]) sat_as = s[WIDTH] ? MINV : MAXV;
    else                        sat_as = s[WIDTH-1:0];
  endfunction

  state_t           state_q;
  logic [WIDTH-1:0] act_q, err_q, a2_q, delta_q, grad_q;
  logic [AW-1:0]    cnt_q, idx_q;
  logic             gvld_q;
  logic [WIDTH-1:0] prod_w, grad_d;

  assign prod_w = sat_mul(delta_q, i_x);

`ifdef BP_TANH_ACC_EN
  logic                      acc_q;
  logic [NUM-1:0][WIDTH-1:0] bank_q;
  logic [WIDTH-1:0]          bank_rd;

  always_comb begin
    bank_rd = '0;
    for (int k = 0; k < NUM; k++)
      if (cnt_q == AW'(k)) bank_rd = bank_q[k];
  end

  assign grad_d = acc_q ? sat_as(bank_rd, prod_w, 1'b0) : prod_w;
`else
  logic unused_cfg;
  assign unused_cfg = i_acc ^ i_clr;
  assign grad_d     = prod_w;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      act_q   <= '0;
      err_q   <= '0;
      a2_q    <= '0;
      delta_q <= '0;
      grad_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      gvld_q  <= 1'b0;
`ifdef BP_TANH_ACC_EN
      acc_q   <= 1'b0;
      bank_q  <= '0;
`endif
    end else begin
      gvld_q <= (state_q == S_GRAD);
      case (state_q)
        S_IDLE: begin
`ifdef BP_TANH_ACC_EN
          // The clear wins over a same-cycle start, so the pass sees an empty bank.
          if (i_clr) bank_q <= '0;
`endif
          if (i_start) begin
            act_q   <= i_act;
            err_q   <= i_err;
`ifdef BP_TANH_ACC_EN
            acc_q   <= i_acc;
`endif
            state_q <= S_SQR;
          end
        end
        S_SQR: begin
          a2_q    <= sat_mul(act_q, act_q);
          state_q <= S_DELTA;
        end
        S_DELTA: begin
          delta_q <= sat_mul(err_q, sat_as(ONE, a2_q, 1'b1));
          cnt_q   <= '0;
          state_q <= S_GRAD;
        end
        S_GRAD: begin
          grad_q <= grad_d;
          idx_q  <= cnt_q;
`ifdef BP_TANH_ACC_EN
          for (int k = 0; k < NUM; k++)
            if (cnt_q == AW'(k)) bank_q[k] <= grad_d;
`endif
          cnt_q  <= cnt_q + AW'(1);
          if (cnt_q == LAST) state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Buffer address: x[0] is requested in DELTA. Each GRAD cycle requests the
  // next word; the last GRAD cycle parks the address at 0.
  assign o_addr = (state_q == S_GRAD && cnt_q != LAST) ? cnt_q + AW'(1) : '0;

  assign o_delta      = delta_q;
  assign o_grad       = grad_q;
  assign o_grad_idx   = idx_q;
  assign o_grad_valid = gvld_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_done       = (state_q == S_DONE);

endmodule

// File: tb/tb_bp_tanh_grad.sv
module tb_bp_tanh_grad;
  localparam int W  = 32;
  localparam int F  = 20;
  localparam int N  = 4;
  localparam int AW = 2;
  localparam longint ONE  = 64'sd1 <<< F;
  localparam longint MAXL = 64'sd2147483647;
  localparam longint MINL = -64'sd2147483648;

  logic          clk = 1'b0, rst = 1'b1, i_start = 1'b0, i_acc = 1'b0, i_clr = 1'b0;
  logic [W-1:0]  i_act = '0, i_err = '0, i_x = '0;
  logic [AW-1:0] o_addr, o_grad_idx;
  logic [W-1:0]  o_delta, o_grad;
  logic          o_grad_valid, o_busy, o_done;

  bp_tanh_grad #(.WIDTH(W), .FRAC(F), .NUM(N), .AW(AW)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_act(i_act), .i_err(i_err),
    .i_acc(i_acc), .i_clr(i_clr), .i_x(i_x), .o_addr(o_addr), .o_delta(o_delta),
    .o_grad(o_grad), .o_grad_idx(o_grad_idx), .o_grad_valid(o_grad_valid),
    .o_busy(o_busy), .o_done(o_done));

  always #5 clk = ~clk;

  // Input buffer with a synchronous read port.
  logic [W-1:0] xmem [N];
  always @(posedge clk) i_x <= xmem[o_addr];

  int npass = 0, ntot = 0, done_cnt = 0, exp_done = 0;
  typedef struct { int idx; longint g; } exp_t;
  exp_t   sb [$];
  longint bank [N];

  task automatic chk(input string nm, input longint act, input longint exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  function automatic longint sx(input logic [W-1:0] v);
    return longint'($signed(v));
  endfunction
  function automatic longint satw(input longint v);
    if (v > MAXL) return MAXL;
    if (v < MINL) return MINL;
    return v;
  endfunction
  // Real-valued product scaled by 2^F, rounded toward -inf, then clamped.
  function automatic longint rmul(input longint a, input longint b);
    return satw((a * b) >>> F);
  endfunction

  // Scoreboard monitor.
  always @(negedge clk) begin : mon
    exp_t e;
    if (o_grad_valid) begin
      if (sb.size() == 0) chk("grad_unexpected", 1, 0);
      else begin
        e = sb.pop_front();
        chk("grad_idx", longint'(o_grad_idx), longint'(e.idx));
        chk("grad", sx(o_grad), e.g);
      end
    end
    if (o_done) done_cnt++;
  end

  // Compute the expected results and push them; return the expected delta.
  task automatic model(input logic [W-1:0] a, e, input logic [N-1:0][W-1:0] x,
                       input bit acc, clr, input int nexp, output longint d);
    longint g;
    d = rmul(sx(e), satw(ONE - rmul(sx(a), sx(a))));
`ifdef BP_TANH_ACC_EN
    if (clr) for (int j = 0; j < N; j++) bank[j] = 0;
`endif
    for (int j = 0; j < N; j++) begin
      g = rmul(d, sx(x[j]));
`ifdef BP_TANH_ACC_EN
      if (acc) g = satw(bank[j] + g);
      bank[j] = g;
`endif
      if (j < nexp) sb.push_back('{j, g});
    end
  endtask

  // This task is entered at a negedge while the DUT is idle. It returns at the
  // negedge of T+N+4, which is the first idle cycle after the pass.
  task automatic run_pass(input logic [W-1:0] a, e, input logic [N-1:0][W-1:0] x,
                          input bit acc, clr, extra, dstart);
    longint d, ea;
    model(a, e, x, acc, clr, N, d);
    for (int j = 0; j < N; j++) xmem[j] = x[j];
    i_act = a; i_err = e; i_acc = acc; i_clr = clr; i_start = 1'b1;
    exp_done++;
    for (int k = 1; k <= N + 4; k++) begin
      @(negedge clk);
      i_start = (extra && k == 2) || (dstart && k == N + 3);
      i_clr   = 1'b0;
      i_acc   = 1'($urandom);
      i_act   = $urandom;
      i_err   = $urandom;
      chk("busy", longint'(o_busy), longint'(k <= N + 3));
      chk("done", longint'(o_done), longint'(k == N + 3));
      ea = 0;
      if (k >= 3 && k <= N + 1) ea = k - 2;
      chk("addr", longint'(o_addr), ea);
      if (k == 3) chk("delta", sx(o_delta), d);
    end
    i_start = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_addr"}, longint'(o_addr), 0);
    chk({nm, "_delta"}, longint'(o_delta), 0);
    chk({nm, "_grad"}, longint'(o_grad), 0);
    chk({nm, "_idx"}, longint'(o_grad_idx), 0);
    chk({nm, "_gvalid"}, longint'(o_grad_valid), 0);
    chk({nm, "_busy"}, longint'(o_busy), 0);
    chk({nm, "_done"}, longint'(o_done), 0);
  endtask

  initial begin : stim
    logic [N-1:0][W-1:0] x;
    longint d;
    int dc;
    for (int j = 0; j < N; j++) begin xmem[j] = '0; bank[j] = 0; end
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // a=0, e=1.0, x = {0.5, -2, 1, 0}
    x = {32'h0, 32'h00100000, 32'hFFE00000, 32'h00080000};
    run_pass(32'h0, 32'h00100000, x, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("delta_vec1", sx(o_delta), 64'h00100000);

    // a=0.5, e=2.0 -> delta 1.5 (back-to-back start)
    for (int j = 0; j < N; j++) x[j] = $urandom_range(32'h003FFFFF, 0) - 32'h00200000;
    run_pass(32'h00080000, 32'h00200000, x, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("delta_vec2", sx(o_delta), 64'h00180000);

    // a=1.0 -> delta 0; a stray start at T+2 must be ignored
    run_pass(32'h00100000, $urandom, x, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("delta_vec3", sx(o_delta), 0);

    // Saturation, both signs; a start during DONE must be ignored
    x = {32'h0, 32'h0, 32'h0, 32'h00400000};
    run_pass(32'h0, 32'h7FFFFFFF, x, 1'b0, 1'b0, 1'b0, 1'b1);
    x = {32'h0, 32'h0, 32'h0, 32'hFFC00000};
    run_pass(32'h0, 32'h7FFFFFFF, x, 1'b0, 1'b0, 1'b0, 1'b0);

    // Accumulation: clear, then pass i_acc=0 followed by pass i_acc=1
    x = {32'h0, 32'h0, 32'h0, 32'h00080000};
    run_pass(32'h0, 32'h00100000, x, 1'b0, 1'b1, 1'b0, 1'b0);
    run_pass(32'h0, 32'h00100000, x, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset at T+4: only grad 0 reaches the output, and o_done never fires
    for (int j = 0; j < N; j++) x[j] = $urandom;
    model(32'h00040000, 32'h00100000, x, 1'b1, 1'b0, 1, d);
    for (int j = 0; j < N; j++) xmem[j] = x[j];
    i_act = 32'h00040000; i_err = 32'h00100000; i_acc = 1'b1; i_start = 1'b1;
    dc = done_cnt;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      i_start = 1'b0;
      if (k == 4) rst = 1'b1;
    end
    @(negedge clk);
    chk_zero("abort");
    chk("abort_no_done", longint'(done_cnt), longint'(dc));
    rst = 1'b0;
    for (int j = 0; j < N; j++) bank[j] = 0;
    @(negedge clk);
    x = {32'h0, 32'h00100000, 32'hFFE00000, 32'h00080000};
    run_pass(32'h0, 32'h00100000, x, 1'b1, 1'b0, 1'b0, 1'b0);

    // Random passes: the first half use in-range values, the second half full-range
    for (int r = 0; r < 24; r++) begin
      logic [W-1:0] a, e;
      for (int j = 0; j < N; j++)
        x[j] = (r < 12) ? $urandom_range(32'h007FFFFF, 0) - 32'h00400000 : $urandom;
      a = (r < 12) ? $urandom_range(32'h001FFFFF, 0) - 32'h00100000 : $urandom;
      e = (r < 12) ? $urandom_range(32'h00FFFFFF, 0) - 32'h00800000 : $urandom;
      run_pass(a, e, x, 1'($urandom), ($urandom_range(3, 0) == 0), 1'($urandom), 1'($urandom));
      if ($urandom_range(1, 0) == 1) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("done_count", longint'(done_cnt), longint'(exp_done));
    chk("scoreboard_empty", longint'(sb.size()), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
